// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle; signed ops work on magnitudes and negate in FIXUP.
module ex_muldiv (
   input  logic        clk,
   input  logic        reset,
   input  logic        startIn,
   input  logic [1:0]  opIn,
   input  logic [31:0] operandAIn,
   input  logic [31:0] operandBIn,
   input  logic        writeHiIn,
   input  logic        writeLoIn,
   input  logic [31:0] writeDataIn,
   input  logic        flushIn,
   output logic        busyOut,
   output logic        doneOut,
   output logic        divByZeroOut,
   output logic [31:0] hiOut,
   output logic [31:0] loOut,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MUL   = 3'd1,
      S_DIV   = 3'd2,
      S_FIXUP = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  iter;
   logic [31:0] work_hi, work_lo, op_b, orig_a;
   logic        is_div, neg_q, neg_r, div_zero;

   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic        div_ok;
   logic [31:0] div_rem;
   logic [63:0] prod, prod_neg;
   logic [31:0] fix_hi, fix_lo;
   logic        accept;

   assign dbg_state = state;

   // Handshake: startIn is a request that is accepted only on an IDLE edge without flush;
   // busyOut high means a new request or an MFHI/MFLO must wait; doneOut is a one-cycle result strobe.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (startIn) state_nxt = opIn[1] ? S_DIV : S_MUL;
         S_MUL,
         S_DIV:   if (iter == 5'd31) state_nxt = S_FIXUP;
         S_FIXUP: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flushIn) state_nxt = S_IDLE;
   end

   assign accept = (state == S_IDLE) && (state_nxt != S_IDLE);
   assign a_mag  = (opIn[0] && operandAIn[31]) ? (~operandAIn + 32'd1) : operandAIn;
   assign b_mag  = (opIn[0] && operandBIn[31]) ? (~operandBIn + 32'd1) : operandBIn;

   always_comb begin
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_b} : 33'd0);
      div_shift = {work_hi, work_lo[31]};
      div_ok    = (div_shift >= {1'b0, op_b});
      div_rem   = div_shift[31:0] - op_b;
      prod      = {work_hi, work_lo};
      prod_neg  = ~prod + 64'd1;
      fix_hi    = work_hi;
      fix_lo    = work_lo;
      // A zero divisor reports all-ones quotient and the untouched dividend as remainder.
      if (div_zero) begin
         fix_hi = orig_a;
         fix_lo = 32'hFFFF_FFFF;
      end else if (is_div) begin
         fix_lo = neg_q ? (~work_lo + 32'd1) : work_lo;
         fix_hi = neg_r ? (~work_hi + 32'd1) : work_hi;
      end else if (neg_q) begin
         fix_hi = prod_neg[63:32];
         fix_lo = prod_neg[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         iter         <= 5'd0;
         busyOut      <= 1'b0;
         doneOut      <= 1'b0;
         divByZeroOut <= 1'b0;
         hiOut        <= 32'd0;
         loOut        <= 32'd0;
         work_hi      <= 32'd0;
         work_lo      <= 32'd0;
         op_b         <= 32'd0;
         orig_a       <= 32'd0;
         is_div       <= 1'b0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         div_zero     <= 1'b0;
      end else begin
         state        <= state_nxt;
         busyOut      <= (state_nxt == S_MUL) || (state_nxt == S_DIV) || (state_nxt == S_FIXUP);
         doneOut      <= (state_nxt == S_DONE);
         divByZeroOut <= (state_nxt == S_DONE) && div_zero;
         iter         <= ((state == S_MUL || state == S_DIV) && state_nxt == state) ? iter + 5'd1 : 5'd0;

         if (accept) begin
            is_div   <= opIn[1];
            neg_q    <= opIn[0] && (operandAIn[31] ^ operandBIn[31]);
            neg_r    <= opIn[0] && operandAIn[31];
            div_zero <= opIn[1] && (operandBIn == 32'd0);
            orig_a   <= operandAIn;
            work_hi  <= 32'd0;
            work_lo  <= opIn[1] ? a_mag : b_mag;
            op_b     <= opIn[1] ? b_mag : a_mag;
         end else if (state == S_MUL) begin
            work_hi <= mul_sum[32:1];
            work_lo <= {mul_sum[0], work_lo[31:1]};
         end else if (state == S_DIV) begin
            work_hi <= div_ok ? div_rem : div_shift[31:0];
            work_lo <= {work_lo[30:0], div_ok};
         end

         if (state == S_FIXUP && state_nxt == S_DONE) begin
            hiOut <= fix_hi;
            loOut <= fix_lo;
         end else if (state == S_IDLE && !startIn && !flushIn) begin
            if (writeHiIn) hiOut <= writeDataIn;
            if (writeLoIn) loOut <= writeDataIn;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, signed/unsigned results, divide-by-zero,
// flush, MTHI/MTLO gating and mid-operation reset.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        reset, startIn, writeHiIn, writeLoIn, flushIn;
   logic [1:0]  opIn;
   logic [31:0] operandAIn, operandBIn, writeDataIn;
   logic        busyOut, doneOut, divByZeroOut;
   logic [31:0] hiOut, loOut;
   logic [2:0]  dbg_state;

   int vectors = 0;
   int errors  = 0;

   ex_muldiv dut (
      .clk(clk), .reset(reset), .startIn(startIn), .opIn(opIn),
      .operandAIn(operandAIn), .operandBIn(operandBIn),
      .writeHiIn(writeHiIn), .writeLoIn(writeLoIn), .writeDataIn(writeDataIn),
      .flushIn(flushIn), .busyOut(busyOut), .doneOut(doneOut),
      .divByZeroOut(divByZeroOut), .hiOut(hiOut), .loOut(loOut), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a start for one cycle; returns in the first cycle after the accepting edge.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      opIn = op; operandAIn = a; operandBIn = b; startIn = 1'b1;
      step();
      startIn = 1'b0;
   endtask

   // Waits (bounded) for doneOut; lat counts cycles after acceptance, busy_n counts busy cycles.
   task automatic wait_done(output int lat, output int busy_n, output int overlap);
      lat = 1; busy_n = 0; overlap = 0;
      while (!doneOut && lat < 60) begin
         if (busyOut) busy_n++;
         step();
         lat++;
      end
      if (busyOut && doneOut) overlap++;
   endtask

   task automatic test_reset();
      reset = 1'b1; writeHiIn = 1'b1; writeDataIn = 32'hAAAA_5555;
      step(); step();
      reset = 1'b0; writeHiIn = 1'b0;
      vectors++; if (hiOut !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hiOut); end
      vectors++; if (loOut !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", loOut); end
      vectors++; if (busyOut !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busyOut); end
      vectors++; if (doneOut !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", doneOut); end
      vectors++; if (divByZeroOut !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", divByZeroOut); end
      vectors++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
   endtask

   task automatic test_multu();
      int lat, busy_n, ov;
      start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, busy_n, ov);
      vectors++; if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d want 34", lat); end
      vectors++; if (busy_n !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", busy_n); end
      vectors++; if (ov !== 0) begin errors++; $display("FAIL multu_busy_done_overlap: got %0d want 0", ov); end
      vectors++; if (hiOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hiOut); end
      vectors++; if (loOut !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", loOut); end
      vectors++; if (divByZeroOut !== 1'b0) begin errors++; $display("FAIL multu_dbz: got %b want 0", divByZeroOut); end
      step();
      vectors++; if (doneOut !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", doneOut); end
      vectors++; if (hiOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi_hold: got %h want fffffffe", hiOut); end
   endtask

   task automatic test_signed();
      int lat, busy_n, ov;
      start_op(2'b01, 32'hFFFF_FFFD, 32'd7);
      wait_done(lat, busy_n, ov);
      vectors++; if (lat !== 34) begin errors++; $display("FAIL mult_latency: got %0d want 34", lat); end
      vectors++; if (hiOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hiOut); end
      vectors++; if (loOut !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", loOut); end
      step();
      start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat, busy_n, ov);
      vectors++; if (lat !== 34) begin errors++; $display("FAIL div_latency: got %0d want 34", lat); end
      vectors++; if (loOut !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quot: got %h want fffffffd", loOut); end
      vectors++; if (hiOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_rem: got %h want ffffffff", hiOut); end
      step();
   endtask

   task automatic test_div_zero();
      int lat, busy_n, ov;
      start_op(2'b10, 32'd100, 32'd0);
      wait_done(lat, busy_n, ov);
      vectors++; if (lat !== 34) begin errors++; $display("FAIL dz_latency: got %0d want 34", lat); end
      vectors++; if (loOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quot: got %h want ffffffff", loOut); end
      vectors++; if (hiOut !== 32'd100) begin errors++; $display("FAIL dz_rem: got %h want 00000064", hiOut); end
      vectors++; if (divByZeroOut !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", divByZeroOut); end
      step();
      vectors++; if (divByZeroOut !== 1'b0) begin errors++; $display("FAIL dz_flag_pulse: got %b want 0", divByZeroOut); end
      start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat, busy_n, ov);
      vectors++; if (loOut !== 32'h8000_0000) begin errors++; $display("FAIL ovf_quot: got %h want 80000000", loOut); end
      vectors++; if (hiOut !== 32'd0) begin errors++; $display("FAIL ovf_rem: got %h want 00000000", hiOut); end
      vectors++; if (divByZeroOut !== 1'b0) begin errors++; $display("FAIL ovf_dbz: got %b want 0", divByZeroOut); end
      step();
   endtask

   task automatic test_flush();
      int seen;
      // Prior values: quotient 0x80000000, remainder 0 from the overflow divide.
      start_op(2'b10, 32'd50, 32'd3);
      repeat (4) step();
      opIn = 2'b00; operandAIn = 32'd9; operandBIn = 32'd9; startIn = 1'b1;
      step();
      startIn = 1'b0;
      vectors++; if (dbg_state !== 3'd2) begin errors++; $display("FAIL flush_ignored_start_state: got %0d want 2", dbg_state); end
      repeat (4) step();
      flushIn = 1'b1;
      step();
      flushIn = 1'b0;
      vectors++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL flush_state: got %0d want 0", dbg_state); end
      vectors++; if (busyOut !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busyOut); end
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (doneOut) seen++;
         step();
      end
      vectors++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", seen); end
      vectors++; if (loOut !== 32'h8000_0000) begin errors++; $display("FAIL flush_lo_hold: got %h want 80000000", loOut); end
      vectors++; if (hiOut !== 32'd0) begin errors++; $display("FAIL flush_hi_hold: got %h want 00000000", hiOut); end
   endtask

   task automatic test_writes();
      int lat, busy_n, ov;
      writeHiIn = 1'b1; writeDataIn = 32'h0000_1234;
      step();
      writeHiIn = 1'b0;
      vectors++; if (hiOut !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi: got %h want 00001234", hiOut); end
      vectors++; if (loOut !== 32'h8000_0000) begin errors++; $display("FAIL mthi_lo_hold: got %h want 80000000", loOut); end
      writeHiIn = 1'b1; writeLoIn = 1'b1; writeDataIn = 32'hCAFE_0001;
      step();
      writeHiIn = 1'b0; writeLoIn = 1'b0;
      vectors++; if (hiOut !== 32'hCAFE_0001) begin errors++; $display("FAIL mthilo_hi: got %h want cafe0001", hiOut); end
      vectors++; if (loOut !== 32'hCAFE_0001) begin errors++; $display("FAIL mthilo_lo: got %h want cafe0001", loOut); end
      writeLoIn = 1'b1; writeDataIn = 32'hDEAD_BEEF;
      start_op(2'b00, 32'd2, 32'd3);
      vectors++; if (busyOut !== 1'b1) begin errors++; $display("FAIL start_wins_busy: got %b want 1", busyOut); end
      vectors++; if (loOut !== 32'hCAFE_0001) begin errors++; $display("FAIL start_wins_lo: got %h want cafe0001", loOut); end
      repeat (5) step();
      vectors++; if (loOut !== 32'hCAFE_0001) begin errors++; $display("FAIL mtlo_busy_lo: got %h want cafe0001", loOut); end
      writeLoIn = 1'b0;
      wait_done(lat, busy_n, ov);
      vectors++; if (loOut !== 32'd6) begin errors++; $display("FAIL mul_small_lo: got %h want 00000006", loOut); end
      vectors++; if (hiOut !== 32'd0) begin errors++; $display("FAIL mul_small_hi: got %h want 00000000", hiOut); end
      step();
   endtask

   task automatic test_reset_mid();
      int lat, busy_n, ov, seen;
      start_op(2'b01, 32'hFFFF_FFF0, 32'd5);
      repeat (19) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      vectors++; if (hiOut !== 32'd0) begin errors++; $display("FAIL midrst_hi: got %h want 00000000", hiOut); end
      vectors++; if (loOut !== 32'd0) begin errors++; $display("FAIL midrst_lo: got %h want 00000000", loOut); end
      vectors++; if (busyOut !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busyOut); end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (doneOut) seen++;
         step();
      end
      vectors++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen); end
      start_op(2'b01, 32'hFFFF_FFFE, 32'd3);
      wait_done(lat, busy_n, ov);
      vectors++; if (lat !== 34) begin errors++; $display("FAIL postrst_latency: got %0d want 34", lat); end
      vectors++; if (hiOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL postrst_hi: got %h want ffffffff", hiOut); end
      vectors++; if (loOut !== 32'hFFFF_FFFA) begin errors++; $display("FAIL postrst_lo: got %h want fffffffa", loOut); end
      step();
   endtask

   task automatic test_back_to_back();
      int lat, busy_n, ov;
      start_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0010);
      wait_done(lat, busy_n, ov);
      vectors++; if (loOut !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_quot: got %h want 0fffffff", loOut); end
      vectors++; if (hiOut !== 32'h0000_000F) begin errors++; $display("FAIL divu_rem: got %h want 0000000f", hiOut); end
      // Start raised during DONE must be ignored; held into IDLE it is accepted.
      opIn = 2'b11; operandAIn = 32'd7; operandBIn = 32'hFFFF_FFFE; startIn = 1'b1;
      step();
      vectors++; if (busyOut !== 1'b0) begin errors++; $display("FAIL start_in_done: got busy %b want 0", busyOut); end
      step();
      startIn = 1'b0;
      wait_done(lat, busy_n, ov);
      vectors++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency: got %0d want 34", lat); end
      vectors++; if (loOut !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_quot: got %h want fffffffd", loOut); end
      vectors++; if (hiOut !== 32'd1) begin errors++; $display("FAIL b2b_rem: got %h want 00000001", hiOut); end
      step();
   endtask

   initial begin
      reset = 1'b1; startIn = 1'b0; opIn = 2'b00; operandAIn = 32'd0; operandBIn = 32'd0;
      writeHiIn = 1'b0; writeLoIn = 1'b0; writeDataIn = 32'd0; flushIn = 1'b0;
      test_reset();
      test_multu();
      test_signed();
      test_div_zero();
      test_flush();
      test_writes();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
